// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Assembles two-byte request frames (command, then sensor address) from the
// UART receiver byte stream, validates them, and hands accepted requests to
// the sensor controller as a one-cycle strobe. Rejected or lost frames raise
// a one-cycle error strobe with a 2-bit reason code for the transmitter.
//
// Error codes on codigoErro (meaningful only while erroFrame=1):
//   00 - address byte did not arrive within CLOCKS_TIMEOUT clocks
//   01 - command code out of range (reported ahead of a bad address)
//   10 - address code out of range
//   11 - a byte arrived while a validated frame was still pending (dropped)

module uart_frame_decoder #(
  parameter int CLOCKS_TIMEOUT = 208360,
  parameter int NUM_COMANDOS   = 8,
  parameter int NUM_ENDERECOS  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bitsEstaoRecebidos,
  input  logic [7:0] byteCompleto,
  input  logic       ocupado,
  output logic       comandoValido,
  output logic [7:0] codigoComando,
  output logic [7:0] enderecoSensor,
  output logic       erroFrame,
  output logic [1:0] codigoErro
);

  // Counter wide enough to hold CLOCKS_TIMEOUT itself.
  localparam int CNT_W = $clog2(CLOCKS_TIMEOUT + 1);

  // Last count value before the frame is declared lost.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_TIMEOUT - 1);

  // Range limits widened by one bit so a limit of 256 still compares correctly.
  localparam logic [8:0] CMD_LIMIT  = 9'(NUM_COMANDOS);
  localparam logic [8:0] ADDR_LIMIT = 9'(NUM_ENDERECOS);

  localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD  = 2'b01;
  localparam logic [1:0] ERR_BAD_ADDR = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO,      // waiting for a command byte
    ESPERA_END,  // command captured, waiting for the address byte
    VALIDA,      // both bytes captured, range-checking them
    RETEM        // valid frame held until the sensor controller is free
  } state_t;

  state_t           state_q;
  logic [7:0]       cmd_q;
  logic [7:0]       addr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic             cmd_valido_q;
  logic [7:0]       cod_cmd_q;
  logic [7:0]       end_sensor_q;
  logic             erro_q;
  logic [1:0]       cod_erro_q;

  logic             cmd_ok;
  logic             addr_ok;

  // Range checks on the captured frame; only consulted in VALIDA.
  assign cmd_ok  = ({1'b0, cmd_q}  < CMD_LIMIT);
  assign addr_ok = ({1'b0, addr_q} < ADDR_LIMIT);

  // Inter-byte timeout counter advances by one each idle cycle in ESPERA_END.
  assign count_d = count_q + CNT_W'(1);

  // Frame FSM with registered strobes, codes and request outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= OCIOSO;
      cmd_q        <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      cmd_valido_q <= 1'b0;
      cod_cmd_q    <= '0;
      end_sensor_q <= '0;
      erro_q       <= 1'b0;
      cod_erro_q   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      cmd_valido_q <= 1'b0;
      erro_q       <= 1'b0;

      case (state_q)
        OCIOSO: begin
          if (bitsEstaoRecebidos) begin
            cmd_q   <= byteCompleto;
            count_q <= '0;
            state_q <= ESPERA_END;
          end
        end

        ESPERA_END: begin
          // An address byte on the final count still completes the frame.
          if (bitsEstaoRecebidos) begin
            addr_q  <= byteCompleto;
            state_q <= VALIDA;
          end else if (count_q == CNT_LAST) begin
            erro_q     <= 1'b1;
            cod_erro_q <= ERR_TIMEOUT;
            state_q    <= OCIOSO;
          end else begin
            count_q <= count_d;
          end
        end

        VALIDA: begin
          if (!cmd_ok) begin
            // A range error masks any overrun byte arriving this cycle.
            erro_q     <= 1'b1;
            cod_erro_q <= ERR_BAD_CMD;
            state_q    <= OCIOSO;
          end else if (!addr_ok) begin
            erro_q     <= 1'b1;
            cod_erro_q <= ERR_BAD_ADDR;
            state_q    <= OCIOSO;
          end else begin
            // Frame is good: an incoming byte is dropped and reported,
            // but the pending request still goes out.
            if (bitsEstaoRecebidos) begin
              erro_q     <= 1'b1;
              cod_erro_q <= ERR_OVERRUN;
            end
            if (!ocupado) begin
              cmd_valido_q <= 1'b1;
              cod_cmd_q    <= cmd_q;
              end_sensor_q <= addr_q;
              state_q      <= OCIOSO;
            end else begin
              state_q <= RETEM;
            end
          end
        end

        RETEM: begin
          if (bitsEstaoRecebidos) begin
            erro_q     <= 1'b1;
            cod_erro_q <= ERR_OVERRUN;
          end
          if (!ocupado) begin
            cmd_valido_q <= 1'b1;
            cod_cmd_q    <= cmd_q;
            end_sensor_q <= addr_q;
            state_q      <= OCIOSO;
          end
        end

        default: begin
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign comandoValido  = cmd_valido_q;
  assign codigoComando  = cod_cmd_q;
  assign enderecoSensor = end_sensor_q;
  assign erroFrame      = erro_q;
  assign codigoErro     = cod_erro_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder
// Drives directed and randomized frames into uart_frame_decoder and compares
// every strobe it produces (cycle, kind, code/payload) against an event list
// predicted from the frame-level rules: latency, timeout window, busy hold,
// overrun and error priority.

module tb_uart_frame_decoder;

  localparam int T  = 64;
  localparam int NC = 8;
  localparam int NE = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bitsEstaoRecebidos = 1'b0;
  logic [7:0] byteCompleto = 8'h00;
  logic       ocupado = 1'b0;
  logic       comandoValido;
  logic [7:0] codigoComando;
  logic [7:0] enderecoSensor;
  logic       erroFrame;
  logic [1:0] codigoErro;

  uart_frame_decoder #(
    .CLOCKS_TIMEOUT(T),
    .NUM_COMANDOS  (NC),
    .NUM_ENDERECOS (NE)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bitsEstaoRecebidos(bitsEstaoRecebidos),
    .byteCompleto      (byteCompleto),
    .ocupado           (ocupado),
    .comandoValido     (comandoValido),
    .codigoComando     (codigoComando),
    .enderecoSensor    (enderecoSensor),
    .erroFrame         (erroFrame),
    .codigoErro        (codigoErro)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge.
  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  typedef struct {
    int edge_i;
    int kind;   // 0 = error strobe, 1 = command strobe
    int code;
    int cmd;
    int addr;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int last_cmd  = 0;
  int last_addr = 0;

  // Observed strobes, recorded mid-cycle; error first when both fire together.
  always @(negedge clock) begin
    if (!reset) begin
      if (erroFrame)
        obs_q.push_back('{edge_n, 0, int'(codigoErro), 0, 0});
      if (comandoValido)
        obs_q.push_back('{edge_n, 1, 0, int'(codigoComando), int'(enderecoSensor)});
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_err(input int e, input int code);
    exp_q.push_back('{e, 0, code, 0, 0});
  endtask

  task automatic push_val(input int e, input int c, input int a);
    exp_q.push_back('{e, 1, 0, c, a});
  endtask

  // Compare the strobes seen during one transaction with the prediction.
  task automatic compare_events(input string name);
    int n;
    check_eq({name, ".n_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({name, ".edge"}, obs_q[i].edge_i, exp_q[i].edge_i);
      check_eq({name, ".kind"}, obs_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == 0) begin
        check_eq({name, ".err_code"}, obs_q[i].code, exp_q[i].code);
      end else begin
        check_eq({name, ".cmd"}, obs_q[i].cmd, exp_q[i].cmd);
        check_eq({name, ".addr"}, obs_q[i].addr, exp_q[i].addr);
      end
    end
    check_eq({name, ".hold_cmd"}, int'(codigoComando), last_cmd);
    check_eq({name, ".hold_addr"}, int'(enderecoSensor), last_addr);
    $display("txn %s: events=%0d expected=%0d cmd_out=%02h addr_out=%02h",
             name, obs_q.size(), exp_q.size(), codigoComando, enderecoSensor);
    obs_q.delete();
    exp_q.delete();
  endtask

  // One-cycle byte strobe; returns the edge on which the DUT sampled it.
  task automatic send_byte(input logic [7:0] b, output int s);
    byteCompleto       = b;
    bitsEstaoRecebidos = 1'b1;
    @(posedge clock); #1;
    s = edge_n;
    bitsEstaoRecebidos = 1'b0;
  endtask

  // Frame: address sampled g edges after the command; ocupado seen high on
  // the b edges after the address; optional extra byte sampled d edges after.
  task automatic run_frame(input string name, input logic [7:0] c, input logic [7:0] a,
                           input int g, input int b, input int d, input logic [7:0] xb);
    int s1, s2;
    bit bad_c, bad_a;
    send_byte(c, s1);
    repeat (g - 1) begin @(posedge clock); #1; end
    send_byte(a, s2);
    for (int j = 1; j <= b + 3; j++) begin
      bitsEstaoRecebidos = (j == d);
      if (j == d) byteCompleto = xb;
      ocupado = (j <= b);
      @(posedge clock); #1;
    end
    bitsEstaoRecebidos = 1'b0;
    ocupado = 1'b0;
    repeat (4) begin @(posedge clock); #1; end

    bad_c = (int'(c) >= NC);
    bad_a = (int'(a) >= NE);
    if (bad_c || bad_a) begin
      push_err(s2 + 1, bad_c ? 1 : 2);
    end else begin
      if (d > 0) push_err(s2 + d, 3);
      push_val(s2 + 1 + b, int'(c), int'(a));
      last_cmd  = int'(c);
      last_addr = int'(a);
    end
    compare_events(name);
  endtask

  // Command byte with no address: lost-frame error T edges after it.
  task automatic run_timeout(input string name, input logic [7:0] c);
    int s1;
    send_byte(c, s1);
    repeat (T + 4) begin @(posedge clock); #1; end
    push_err(s1 + T, 0);
    compare_events(name);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_eq("rst.comandoValido", int'(comandoValido), 0);
    check_eq("rst.codigoComando", int'(codigoComando), 0);
    check_eq("rst.enderecoSensor", int'(enderecoSensor), 0);
    check_eq("rst.erroFrame", int'(erroFrame), 0);
    check_eq("rst.codigoErro", int'(codigoErro), 0);
    repeat (2) begin @(posedge clock); #1; end

    // Basic decode with a quarter-window gap.
    run_frame("basic", 8'h03, 8'h11, T / 4, 0, 0, 8'h00);
    // Range errors; outputs keep the last accepted request.
    run_frame("bad_cmd", 8'h09, 8'h05, 3, 0, 0, 8'h00);
    run_frame("bad_addr", 8'h02, 8'h20, 3, 0, 0, 8'h00);
    run_frame("bad_both", 8'hF0, 8'hF0, 2, 0, 0, 8'h00);
    // Timeout, then recovery and the final-count boundary.
    run_timeout("timeout", 8'h01);
    run_frame("after_to", 8'h04, 8'h07, 2, 0, 0, 8'h00);
    run_frame("final_count", 8'h03, 8'h1F, T, 0, 0, 8'h00);
    run_frame("count_m1", 8'h02, 8'h01, T - 1, 0, 0, 8'h00);
    // Busy hold, overrun during hold, overrun on release edge.
    run_frame("busy", 8'h05, 8'h0A, 2, 100, 0, 8'h00);
    run_frame("busy_ovr", 8'h06, 8'h0B, 1, 30, 10, 8'hAA);
    run_frame("busy_ovr_rel", 8'h07, 8'h0C, 1, 5, 6, 8'h01);
    // Overrun while validating: reported with a good frame, masked by a bad one.
    run_frame("valida_ovr", 8'h07, 8'h1F, 1, 0, 1, 8'h33);
    run_frame("valida_bad_ovr", 8'h08, 8'h00, 1, 0, 1, 8'h55);

    // Reset mid-frame discards the partial frame and clears the outputs.
    send_byte(8'h05, s);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("midrst.comandoValido", int'(comandoValido), 0);
    check_eq("midrst.codigoComando", int'(codigoComando), 0);
    check_eq("midrst.enderecoSensor", int'(enderecoSensor), 0);
    check_eq("midrst.erroFrame", int'(erroFrame), 0);
    check_eq("midrst.codigoErro", int'(codigoErro), 0);
    check_eq("midrst.no_events", obs_q.size(), 0);
    obs_q.delete();
    last_cmd  = 0;
    last_addr = 0;
    run_frame("post_rst", 8'h00, 8'h1F, 3, 0, 0, 8'h00);

    // Back-to-back frames.
    run_frame("b2b_1", 8'h01, 8'h02, 1, 0, 0, 8'h00);
    run_frame("b2b_2", 8'h06, 8'h1E, 1, 0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int kind, g, b, d;
      logic [7:0] c, a, xb;
      bit bad;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        run_timeout("rnd_to", 8'($urandom_range(0, 255)));
      end else begin
        c  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, NC - 1)) : 8'($urandom_range(NC, 255));
        a  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, NE - 1)) : 8'($urandom_range(NE, 255));
        xb = 8'($urandom_range(0, 255));
        g  = ($urandom_range(0, 4) == 0) ? T : $urandom_range(1, T);
        b  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
        bad = (int'(c) >= NC) || (int'(a) >= NE);
        if (bad || b == 0) d = $urandom_range(0, 1);
        else d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, b + 1);
        run_frame("rnd", c, a, g, b, d, xb);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
